uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter: serializes one parallel word per valid/ready handshake onto a single TX line.
- Frame format: start bit, data LSB-first, optional parity bit, stop bit(s).
- Companion to uart_rx. Same parameter set, so a board-level top can pair the two on one link (e.g. loopback or echo tests on CLOCK_50).

Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bits/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer truncation (434 at defaults).
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- STOP_BITS, 1: stop bits per frame, legal values 1 or 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Other values are illegal and flagged by elaboration-time assertion.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- i_data_valid  in  1  word on i_data is offered for transmission.
- i_data  in  DATA_BITS  word to send; sampled only on the accept cycle.
- o_ready  out  1  block can accept a word this cycle.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  frame in progress.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (n_rst). All outputs are registered.
- Reset values: o_tx=1, o_ready=1, o_busy=0, state=IDLE, bit counter=0, baud counter=0.
- Reset asserted mid-frame: the frame aborts immediately and o_tx returns high asynchronously. No partial frame resumes after release.
- Accept: occurs on a rising clk edge where i_data_valid=1 and o_ready=1. i_data is latched into a shift register. Parity is computed from the latched word: odd means the total number of 1s in data+parity is odd; even means that total is even.
- After accept (next cycle): o_ready=0, o_busy=1, o_tx=0 (start bit). Latency from accept edge to start bit on the line is 1 clock.
- Changes on i_data or i_data_valid while o_ready=0 are ignored.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- Each bit period lasts exactly CLKS_PER_BIT clocks. The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
- DATA: drives bit 0 first and shifts right. Leaves after DATA_BITS periods.
- PARITY: one period carrying the computed parity bit.
- STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT clocks.
- Return to IDLE: on the final clock of STOP the state moves to IDLE. The following cycle has o_ready=1, o_busy=0, o_tx=1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks from start-bit edge to IDLE.
- Back-to-back frames: if i_data_valid stays high, the next word is accepted in the first IDLE cycle. The next start bit begins 1 clock later, so the line sees one extra high clock between frames. This is legal as stop-bit extension.
- In IDLE with i_data_valid=0: o_tx stays 1 indefinitely and the counters are held at 0.

Test Plan (CLK_FREQ=1000, BAUD_RATE=100 -> CLKS_PER_BIT=10, unless stated):
- Reset release, no valid for 100 clocks -> o_tx=1, o_ready=1, o_busy=0 throughout.
- PARITY=0, DATA_BITS=8, STOP_BITS=1: send 0xA5 -> start bit 1 clock after accept. Line bits are 0,1,0,1,0,0,1,0,1,1, each 10 clocks wide. o_ready returns 100 clocks after the start bit.
- PARITY=2: send 0x55 -> parity bit 0. PARITY=1: send 0x55 -> parity bit 1. PARITY=2: send 0x07 -> parity bit 1. Frame is 110 clocks.
- STOP_BITS=2, i_data_valid held high with 0x00 then 0xFF -> each stop phase is 20 clocks high, plus exactly 1 idle-high clock before the next start bit. The second frame's data bits are all 1.
- Change i_data mid-frame from 0x3C to 0xC3 -> transmitted data stays 0x3C. i_data_valid during busy is not accepted (o_ready stays 0).
- Assert n_rst during data bit 4 of a frame -> o_tx=1 asynchronously. After release, o_ready=1 and the next accepted word is sent as a full, correct frame.
- Default parameters, send 0x41 -> each bit period measures 434 clocks.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and shifts it
// out as start bit, LSB-first data, optional parity bit and stop bit(s).
// The line idles high. All outputs come straight from flops.
module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_data_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  // Reject parameter sets the frame logic was not built for.
  generate
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ must be at least BAUD_RATE");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;

  // Last clock of the current bit period.
  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state and registered-output logic. The line value for the next
  // cycle is chosen together with the state transition so o_tx is a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    // Baud counter free-runs inside a frame, wrapping every bit period.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (i_data_valid && ready_q) begin
          shift_d = i_data;
          // Even: parity bit equals XOR of data. Odd: its complement.
          par_d   = (PARITY == 1) ? ~^i_data : ^i_data;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            // Final stop clock: the next cycle is IDLE and ready again.
            state_d = S_IDLE;
            bit_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame and releases the line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Five instances cover no parity, even, odd,
// two stop bits and the default baud setup; a selector routes the
// handshake to one instance and muxes its outputs back for checking.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] sel = 3'd0;

  logic [4:0] tx_v, rdy_v, busy_v;
  logic       m_tx, m_rdy, m_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign m_tx   = tx_v[sel];
  assign m_rdy  = rdy_v[sel];
  assign m_busy = busy_v[sel];

  // 0: no parity, 1 stop, 10 clocks/bit
  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u_p0 (
    .clk(clk), .n_rst(n_rst), .i_data_valid(valid && sel == 3'd0), .i_data(din),
    .o_ready(rdy_v[0]), .o_tx(tx_v[0]), .o_busy(busy_v[0]));
  // 1: even parity
  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u_even (
    .clk(clk), .n_rst(n_rst), .i_data_valid(valid && sel == 3'd1), .i_data(din),
    .o_ready(rdy_v[1]), .o_tx(tx_v[1]), .o_busy(busy_v[1]));
  // 2: odd parity
  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u_odd (
    .clk(clk), .n_rst(n_rst), .i_data_valid(valid && sel == 3'd2), .i_data(din),
    .o_ready(rdy_v[2]), .o_tx(tx_v[2]), .o_busy(busy_v[2]));
  // 3: two stop bits
  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) u_s2 (
    .clk(clk), .n_rst(n_rst), .i_data_valid(valid && sel == 3'd3), .i_data(din),
    .o_ready(rdy_v[3]), .o_tx(tx_v[3]), .o_busy(busy_v[3]));
  // 4: default parameters, 434 clocks/bit
  uart_tx u_def (
    .clk(clk), .n_rst(n_rst), .i_data_valid(valid && sel == 3'd4), .i_data(din),
    .o_ready(rdy_v[4]), .o_tx(tx_v[4]), .o_busy(busy_v[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the selected instance idle. Offers d, then
  // after the accept edge drives mid_d/mid_v for the rest of the frame.
  // bits holds the line sequence written left to right (start bit first).
  // Each line bit must hold for exactly cpb clocks, ready must stay low
  // and busy high for the whole frame, and the line returns to idle.
  task automatic frame(input string tag, input logic [7:0] d, input int cpb,
                       input logic [15:0] bits, input int nb,
                       input logic [7:0] mid_d, input logic mid_v);
    int good;
    int held;
    chk({tag, "_rdy_pre"}, 32'(m_rdy), 32'd1);
    din   = d;
    valid = 1'b1;
    @(negedge clk);
    din   = mid_d;
    valid = mid_v;
    held  = 0;
    for (int i = 0; i < nb; i++) begin
      good = 0;
      for (int c = 0; c < cpb; c++) begin
        if (m_tx === bits[nb-1-i]) good++;
        if (m_rdy === 1'b0 && m_busy === 1'b1) held++;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, i), 32'(good), 32'(cpb));
    end
    chk({tag, "_busy_whole_frame"}, 32'(held), 32'(nb * cpb));
    chk({tag, "_rdy_end"},  32'(m_rdy),  32'd1);
    chk({tag, "_busy_end"}, 32'(m_busy), 32'd0);
    chk({tag, "_tx_end"},   32'(m_tx),   32'd1);
  endtask

  initial begin
    int idle_ok;

    // Reset state, applied with an explicit falling edge.
    #2 n_rst = 1'b0;
    #1;
    chk("rst_tx",   32'(m_tx),   32'd1);
    chk("rst_rdy",  32'(m_rdy),  32'd1);
    chk("rst_busy", 32'(m_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Idle with no valid for 100 clocks.
    idle_ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (m_tx === 1'b1 && m_rdy === 1'b1 && m_busy === 1'b0) idle_ok++;
      @(negedge clk);
    end
    chk("idle_100", 32'(idle_ok), 32'd100);

    // No parity: 0xA5 -> 0 10100101 1 on the line.
    sel = 3'd0;
    frame("p0_a5", 8'hA5, 10, 16'b0101001011, 10, 8'hA5, 1'b0);

    // Even parity 0x55 -> parity 0.
    sel = 3'd1;
    frame("even_55", 8'h55, 10, 16'b01010101001, 11, 8'h55, 1'b0);
    // Even parity 0x07 -> parity 1.
    frame("even_07", 8'h07, 10, 16'b01110000011, 11, 8'h07, 1'b0);

    // Odd parity 0x55 -> parity 1.
    sel = 3'd2;
    frame("odd_55", 8'h55, 10, 16'b01010101011, 11, 8'h55, 1'b0);

    // Two stop bits, valid held: 20 stop clocks, 1 idle clock, next start.
    sel = 3'd3;
    frame("s2_00", 8'h00, 10, 16'b00000000011, 11, 8'h00, 1'b1);
    frame("s2_ff", 8'hFF, 10, 16'b01111111111, 11, 8'hFF, 1'b0);

    // Data and valid toggled mid-frame are ignored: 0x3C goes out.
    sel = 3'd0;
    frame("p0_3c_mid", 8'h3C, 10, 16'b0001111001, 10, 8'hC3, 1'b1);
    valid = 1'b0;
    @(negedge clk);
    chk("no_accept_after_mid", 32'(m_rdy), 32'd1);

    // Reset during data bit 4 of 0xA5 (line bit 5, clocks 50..59).
    din   = 8'hA5;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < 55; c++) @(negedge clk);
    chk("abort_pre_tx", 32'(m_tx), 32'd0);
    n_rst = 1'b0;
    #1;
    chk("abort_tx",   32'(m_tx),   32'd1);
    chk("abort_rdy",  32'(m_rdy),  32'd1);
    chk("abort_busy", 32'(m_busy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_abort_tx", 32'(m_tx), 32'd1);
    frame("post_abort_3c", 8'h3C, 10, 16'b0001111001, 10, 8'h3C, 1'b0);

    // Default parameters: 0x41, 434 clocks per bit.
    sel = 3'd4;
    frame("def_41", 8'h41, 434, 16'b0100000101, 10, 8'h41, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
